// File: rtl/fir_pkg.sv
// Shared sizing and state encoding for the FIR coefficient loader slice.
package fir_pkg;
  localparam int W1    = 8;
  localparam int L     = 3;
  localparam int NSETS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;
endpackage

// File: rtl/fir_coef_loader_if.sv
// Upstream sample stream handshake into the coefficient loader.
interface fir_coef_loader_if #(parameter int W1 = fir_pkg::W1);
  logic                 s_valid;
  logic signed [W1-1:0] s_data;
  logic                 s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient register file: NSETS x L entries, one write port, one async read port.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int W1    = fir_pkg::W1,
  parameter int L     = fir_pkg::L,
  parameter int NSETS = fir_pkg::NSETS,
  localparam int SETW = $clog2(NSETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [SETW-1:0]      wr_set,
  input  logic [1:0]           wr_idx,
  input  logic signed [W1-1:0] wr_data,
  input  logic [SETW-1:0]      rd_set,
  input  logic [1:0]           rd_idx,
  output logic signed [W1-1:0] rd_data
);
  logic [NSETS-1:0][L-1:0][W1-1:0] mem;

  // Tap indices beyond the filter length have no storage and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               mem <= '0;
    else if (wr_en && (int'(wr_idx) < L))    mem[wr_set][wr_idx] <= wr_data;
  end

  assign rd_data = (int'(rd_idx) < L) ? $signed(mem[rd_set][rd_idx]) : '0;
endmodule

// File: rtl/fir_coef_loader.sv
// Streams a selected coefficient set into a shift-loaded FIR, then passes samples
// through with zero-stuffing and a saturating starvation counter.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int W1    = fir_pkg::W1,
  parameter int L     = fir_pkg::L,
  parameter int NSETS = fir_pkg::NSETS,
  localparam int SETW = $clog2(NSETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coef_wr_en,
  input  logic [SETW-1:0]      coef_wr_set,
  input  logic [1:0]           coef_wr_idx,
  input  logic signed [W1-1:0] coef_wr_data,
  input  logic [SETW-1:0]      sel_set,
  input  logic                 reload,
  input  logic                 stop,
  fir_coef_loader_if.slave     s,
  output logic                 Load_x,
  output logic signed [W1-1:0] x_in,
  output logic signed [W1-1:0] c_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          underflow_cnt
);
  localparam logic [1:0] LAST = 2'(L - 1);

  state_t               state, state_nx;
  logic                 accept;
  logic [1:0]           cnt;
  logic [SETW-1:0]      act_set;
  logic signed [W1-1:0] rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Reload outranks stop in RUN; LOAD never looks at reload.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: if (reload) begin state_nx = LOAD; accept = 1'b1; end
      LOAD: if (cnt == LAST) state_nx = RUN;
      RUN: begin
        if (reload) begin
          state_nx = LOAD;
          accept   = 1'b1;
        end else if (stop) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      act_set <= '0;
    end else begin
      if (accept) act_set <= sel_set;
      cnt <= (state == LOAD && cnt != LAST) ? cnt + 2'd1 : 2'd0;
    end
  end

  fir_coef_bank #(.W1(W1), .L(L), .NSETS(NSETS)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (coef_wr_en),
    .wr_set  (coef_wr_set),
    .wr_idx  (coef_wr_idx),
    .wr_data (coef_wr_data),
    .rd_set  (act_set),
    .rd_idx  (cnt),
    .rd_data (rd_data)
  );

  // Filter controls trail the state register by one edge; done marks the
  // first edge Load_x rises again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Load_x        <= 1'b1;
      c_in          <= '0;
      x_in          <= '0;
      done          <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      Load_x <= (state != LOAD);
      c_in   <= (state == LOAD) ? rd_data : '0;
      done   <= !Load_x && (state != LOAD);
      x_in   <= (state == RUN && s.s_valid) ? s.s_data : '0;
      if (state == RUN && !s.s_valid && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  assign busy      = (state == LOAD);
  assign s.s_ready = (state == RUN);
endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized and directed bench for fir_coef_loader against a load-countdown reference model.
module tb_fir_coef_loader;
  import fir_pkg::*;
  localparam int SETW = $clog2(NSETS);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 coef_wr_en;
  logic [SETW-1:0]      coef_wr_set;
  logic [1:0]           coef_wr_idx;
  logic signed [W1-1:0] coef_wr_data;
  logic [SETW-1:0]      sel_set;
  logic                 reload, stop;
  logic                 Load_x, busy, done;
  logic signed [W1-1:0] x_in, c_in;
  logic [15:0]          underflow_cnt;

  fir_coef_loader_if #(.W1(W1)) sif ();

  fir_coef_loader dut (
    .clk(clk), .reset(reset), .coef_wr_en(coef_wr_en), .coef_wr_set(coef_wr_set),
    .coef_wr_idx(coef_wr_idx), .coef_wr_data(coef_wr_data), .sel_set(sel_set),
    .reload(reload), .stop(stop), .s(sif), .Load_x(Load_x), .x_in(x_in),
    .c_in(c_in), .busy(busy), .done(done), .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: bank contents, remaining load cycles, run flag, expected outputs.
  int mb [NSETS][L];
  bit m_run;
  int m_left, m_k, m_set;
  int e_loadx, e_c, e_x, e_done, e_uf;

  int cap_c[$];
  int xs[$];
  int done_cnt;
  int filt[L];
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++)
      for (int k = 0; k < L; k++) mb[s][k] = 0;
    m_run = 0; m_left = 0; m_k = 0; m_set = 0;
    e_loadx = 1; e_c = 0; e_x = 0; e_done = 0; e_uf = 0;
  endtask

  task automatic model_step();
    int pl;
    pl = e_loadx;
    if (m_left > 0) begin e_loadx = 0; e_c = mb[m_set][m_k]; end
    else begin e_loadx = 1; e_c = 0; end
    e_done = (pl == 0 && e_loadx == 1) ? 1 : 0;
    e_x = (m_run && sif.s_valid) ? int'(sif.s_data) : 0;
    if (m_run && !sif.s_valid && e_uf < 65535) e_uf++;
    if (m_left > 0) begin
      m_k++; m_left--;
      if (m_left == 0) m_run = 1;
    end else if (reload) begin
      m_left = L; m_k = 0; m_set = int'(sel_set); m_run = 0;
    end else if (m_run && stop) begin
      m_run = 0;
    end
    if (coef_wr_en && int'(coef_wr_idx) < L)
      mb[coef_wr_set][coef_wr_idx] = int'(coef_wr_data);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  task automatic wr(input int set, input int idx, input int val);
    coef_wr_en = 1'b1; coef_wr_set = SETW'(set); coef_wr_idx = 2'(idx);
    coef_wr_data = W1'(val);
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic pulse_reload(input int set);
    sel_set = SETW'(set); reload = 1'b1;
    tick();
    reload = 1'b0; sel_set = SETW'($urandom);
  endtask

  // Single compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("Load_x", int'(Load_x), e_loadx);
      chk("c_in", int'(c_in), e_c);
      chk("x_in", int'(x_in), e_x);
      chk("done", int'(done), e_done);
      chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
      chk("s_ready", int'(sif.s_ready), m_run ? 1 : 0);
      chk("underflow_cnt", int'(underflow_cnt), e_uf);
      if (Load_x === 1'b0) begin
        cap_c.push_back(int'(c_in));
        for (int i = 0; i < L - 1; i++) filt[i] = filt[i+1];
        filt[L-1] = int'(c_in);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    int low;
    reset = 1'b1; coef_wr_en = 0; coef_wr_set = 0; coef_wr_idx = 0; coef_wr_data = 0;
    sel_set = 0; reload = 0; stop = 0; sif.s_valid = 0; sif.s_data = 0;
    done_cnt = 0;
    for (int i = 0; i < L; i++) filt[i] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_Load_x", int'(Load_x), 1);
    chk("rst_c_in", int'(c_in), 0);
    chk("rst_x_in", int'(x_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_uf", int'(underflow_cnt), 0);
    chk("rst_s_ready", int'(sif.s_ready), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Load set 1 = {5,-3,7} from IDLE, then stream 1,2,(gap),3
    wr(1, 0, 5); wr(1, 1, -3); wr(1, 2, 7); wr(1, 3, 99);
    cap_c.delete(); done_cnt = 0;
    pulse_reload(1);
    repeat (3) tick();
    sif.s_valid = 1; sif.s_data = 1; tick(); xs.push_back(int'(x_in));
    sif.s_data = 2; tick(); xs.push_back(int'(x_in));
    sif.s_valid = 0; sif.s_data = 8'sd55; tick(); xs.push_back(int'(x_in));
    sif.s_valid = 1; sif.s_data = 3; tick(); xs.push_back(int'(x_in));
    sif.s_data = 0;
    chk("uf_after_gap", int'(underflow_cnt), 1);
    chk("xs_len", xs.size(), 4);
    if (xs.size() == 4) begin
      chk("x0", xs[0], 1); chk("x1", xs[1], 2); chk("x2", xs[2], 0); chk("x3", xs[3], 3);
    end
    tick();
    chk("load1_len", cap_c.size(), 3);
    if (cap_c.size() == 3) begin
      chk("load1_c0", cap_c[0], 5); chk("load1_c1", cap_c[1], -3); chk("load1_c2", cap_c[2], 7);
    end
    chk("load1_done", done_cnt, 1);
    chk("filt0", filt[0], 5); chk("filt1", filt[1], -3); chk("filt2", filt[2], 7);

    // Reload from RUN with set 2, plus an ignored reload mid-LOAD
    wr(2, 0, 1); wr(2, 1, 1); wr(2, 2, 1);
    cap_c.delete(); done_cnt = 0;
    pulse_reload(2);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (!sif.s_ready) low++;
      reload = (i == 1);
      tick();
    end
    reload = 0;
    chk("ready_low_cycles", low, 3);
    chk("load2_len", cap_c.size(), 3);
    if (cap_c.size() == 3) begin
      chk("load2_c0", cap_c[0], 1); chk("load2_c1", cap_c[1], 1); chk("load2_c2", cap_c[2], 1);
    end
    chk("load2_done", done_cnt, 1);

    // Reset on the second LOAD cycle
    wr(3, 0, -8); wr(3, 1, 17); wr(3, 2, 33);
    pulse_reload(3);
    tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_Load_x", int'(Load_x), 1);
    chk("arst_c_in", int'(c_in), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_uf", int'(underflow_cnt), 0);
    chk("arst_s_ready", int'(sif.s_ready), 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    cap_c.delete();
    repeat (4) tick();
    chk("post_rst_loads", cap_c.size(), 0);
    chk("post_rst_Load_x", int'(Load_x), 1);
    chk("post_rst_busy", int'(busy), 0);

    // Write to the entry being read in the same cycle returns the old value
    wr(0, 0, 2); wr(0, 1, 4); wr(0, 2, 6);
    cap_c.delete();
    pulse_reload(0);
    tick();
    coef_wr_en = 1; coef_wr_set = 0; coef_wr_idx = 1; coef_wr_data = 9;
    tick();
    coef_wr_en = 0;
    repeat (4) tick();
    chk("coll_len", cap_c.size(), 3);
    if (cap_c.size() == 3) chk("coll_old", cap_c[1], 4);
    cap_c.delete();
    pulse_reload(0);
    repeat (5) tick();
    if (cap_c.size() == 3) chk("coll_new", cap_c[1], 9);
    else chk("coll_new_len", cap_c.size(), 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      coef_wr_en = ($urandom % 4 == 0); coef_wr_set = SETW'($urandom);
      coef_wr_idx = 2'($urandom); coef_wr_data = W1'($urandom);
      reload = ($urandom % 16 == 0); sel_set = SETW'($urandom);
      stop = ($urandom % 12 == 0);
      sif.s_valid = ($urandom % 3 != 0); sif.s_data = W1'($urandom);
      tick();
    end
    coef_wr_en = 0; reload = 0; stop = 0;

    // Starve RUN long enough to saturate the counter
    sif.s_valid = 0;
    pulse_reload(1);
    repeat (70000) tick();
    chk("uf_saturated", int'(underflow_cnt), 65535);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
